ssd_bcd_scanner: RTL and testbench

// - N-digit multiplexed seven-segment driver with a built-in decimal (BCD) up/down counter.
// - Sits between the board clock and the SSD pins.
// - Ticks the counter at a slow rate and time-multiplexes digits at a fast scan rate.
// - Drives a one-hot digit select plus a matching segment pattern.

---
 rtl/ssd_bcd_scanner.sv | 167 ++++++++++++++++
 tb/tb_ssd_bcd_scanner.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_bcd_scanner.sv
// Multiplexed seven-segment driver with a built-in BCD up/down counter.
// Optional leading-zero blanking is enabled by defining SSD_LZ_BLANK_EN.
module ssd_bcd_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int COUNT_DIV  = 50000000
) (
  input  logic                    CLK_50MHZ,
  input  logic                    RST,
  input  logic                    count_en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   ssdsel,
  output logic [6:0]              ssdout,
  output logic                    wrap
);

  localparam int BW    = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW    = $clog2(SCAN_DIV);
  localparam int CW    = $clog2(COUNT_DIV);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // Returns {carry_out, incremented value}.
  function automatic logic [BW:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Returns {borrow_out, decremented value}.
  function automatic logic [BW:0] bcd_dec(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return {b, r};
  endfunction

  function automatic logic [BW-1:0] bcd_sanitize(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    for (int i = 0; i < NUM_DIGITS; i++)
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd0 : v[4*i +: 4];
    return r;
  endfunction

  logic [SW-1:0]         scan_cnt;
  logic [CW-1:0]         cnt_div;
  logic [IDX_W-1:0]      idx;
  logic                  scan_tick;
  logic                  count_tick;
  logic [IDX_W-1:0]      next_idx;
  logic [NUM_DIGITS-1:0] next_sel;
  logic [3:0]            next_nib;
  logic [6:0]            next_seg;
  logic [BW:0]           inc_val;
  logic [BW:0]           dec_val;

  assign scan_tick  = (scan_cnt == SW'(SCAN_DIV - 1));
  assign count_tick = (cnt_div == CW'(COUNT_DIV - 1));
  assign next_idx   = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
  assign inc_val    = bcd_inc(bcd_out);
  assign dec_val    = bcd_dec(bcd_out);

`ifdef SSD_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  run;
`endif

  // Segment pattern for the digit that becomes selected on the next scan tick.
  always_comb begin
    next_sel = '0;
    next_nib = '0;
`ifdef SSD_LZ_BLANK_EN
    lz  = '0;
    run = 1'b1;
`endif
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef SSD_LZ_BLANK_EN
      run   = run & (bcd_out[4*i +: 4] == 4'd0);
      lz[i] = run;
`endif
      if (IDX_W'(i) == next_idx) begin
        next_sel[i] = 1'b1;
        next_nib    = bcd_out[4*i +: 4];
      end
    end
    next_seg = seg7(next_nib);
`ifdef SSD_LZ_BLANK_EN
    if ((next_idx != '0) && lz[next_idx]) next_seg = 7'b0000000;
`endif
  end

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      scan_cnt <= '0;
      cnt_div  <= '0;
      bcd_out  <= '0;
      idx      <= '0;
      ssdsel   <= NUM_DIGITS'(1);
      ssdout   <= 7'b0111111;
      wrap     <= 1'b0;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;

      // Load overrides a coincident tick and restarts the count interval.
      if (load) begin
        bcd_out <= bcd_sanitize(load_val);
        cnt_div <= '0;
        wrap    <= 1'b0;
      end else begin
        cnt_div <= count_tick ? '0 : cnt_div + 1'b1;
        if (count_tick && count_en) begin
          {wrap, bcd_out} <= up_dn ? inc_val : dec_val;
        end else begin
          wrap <= 1'b0;
        end
      end

      if (scan_tick) begin
        idx    <= next_idx;
        ssdsel <= next_sel;
        ssdout <= next_seg;
      end
    end
  end

endmodule

// File: tb/tb_ssd_bcd_scanner.sv
// Scoreboard bench for ssd_bcd_scanner (NUM_DIGITS=4, SCAN_DIV=4, COUNT_DIV=8).
// Expected blanking values follow SSD_LZ_BLANK_EN when it is defined.
module tb_ssd_bcd_scanner;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] S9 = 7'b1101111;
`ifdef SSD_LZ_BLANK_EN
  localparam logic [6:0] BL = 7'b0000000;
`else
  localparam logic [6:0] BL = 7'b0111111;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        count_en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] bcd_out;
  logic [3:0]  ssdsel;
  logic [6:0]  ssdout;
  logic        wrap;

  always #5 clk = ~clk;

  ssd_bcd_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .COUNT_DIV(8)) dut (
    .CLK_50MHZ(clk),
    .RST      (rst),
    .count_en (count_en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .bcd_out  (bcd_out),
    .ssdsel   (ssdsel),
    .ssdout   (ssdout),
    .wrap     (wrap)
  );

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  event chk_ev;

  always @(posedge clk) cyc <= cyc + 1;

  // sig: 0=bcd_out 1=ssdsel 2=ssdout 3=wrap; queue kept sorted by cycle.
  task automatic expect_at(input int c, input int sig, input logic [31:0] v, input string nm);
    exp_t e;
    int   i;
    e.cyc = c;
    e.sig = sig;
    e.val = v;
    e.nm  = nm;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        case (e.sig)
          0:       act = 32'(bcd_out);
          1:       act = 32'(ssdsel);
          2:       act = 32'(ssdout);
          default: act = 32'(wrap);
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h want=%h", e.nm, cyc, act, e.val);
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d want=0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset(output int r);
    drain();
    @(posedge clk); #1;
    rst      = 1'b0;
    load     = 1'b0;
    count_en = 1'b0;
    up_dn    = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    r   = cyc;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r;
    rst      = 1'b0;
    count_en = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_at(cyc, 0, 0,       "por_bcd");
    expect_at(cyc, 1, 4'b0001, "por_sel");
    expect_at(cyc, 2, S0,      "por_seg");
    expect_at(cyc, 3, 0,       "por_wrap");
    ->chk_ev;

    // Scan rotation with a static value
    do_reset(r);
    load = 1'b1; load_val = 16'h1234;
    expect_at(r + 1,  0, 16'h1234, "scan_load");
    expect_at(r + 3,  1, 4'b0001,  "scan_sel_hold");
    expect_at(r + 3,  2, S0,       "scan_seg_stale");
    expect_at(r + 4,  1, 4'b0010,  "scan_sel1");
    expect_at(r + 4,  2, S3,       "scan_seg1");
    expect_at(r + 8,  1, 4'b0100,  "scan_sel2");
    expect_at(r + 8,  2, S2,       "scan_seg2");
    expect_at(r + 12, 1, 4'b1000,  "scan_sel3");
    expect_at(r + 12, 2, S1,       "scan_seg3");
    expect_at(r + 16, 1, 4'b0001,  "scan_sel0");
    expect_at(r + 16, 2, S4,       "scan_seg0");
    expect_at(r + 17, 0, 16'h1234, "scan_hold_noen");
    @(posedge clk); #1; load = 1'b0;
    drain();

    // Up count with carry wrap
    do_reset(r);
    load = 1'b1; load_val = 16'h9998; count_en = 1'b1; up_dn = 1'b1;
    expect_at(r + 1,  0, 16'h9998, "up_load");
    expect_at(r + 4,  2, S9,       "up_seg9");
    expect_at(r + 8,  0, 16'h9998, "up_pre_tick");
    expect_at(r + 9,  0, 16'h9999, "up_tick1");
    expect_at(r + 9,  3, 0,        "up_nowrap");
    expect_at(r + 16, 0, 16'h9999, "up_pre_wrap");
    expect_at(r + 16, 3, 0,        "up_wrap_low");
    expect_at(r + 17, 0, 16'h0000, "up_wrapped");
    expect_at(r + 17, 3, 1,        "up_wrap_pulse");
    expect_at(r + 18, 3, 0,        "up_wrap_clear");
    expect_at(r + 25, 0, 16'h0001, "up_after_wrap");
    @(posedge clk); #1; load = 1'b0;
    drain();

    // Down count with borrow wrap
    do_reset(r);
    load = 1'b1; load_val = 16'h0000; count_en = 1'b1; up_dn = 1'b0;
    expect_at(r + 1,  0, 16'h0000, "dn_load");
    expect_at(r + 8,  0, 16'h0000, "dn_pre_tick");
    expect_at(r + 9,  0, 16'h9999, "dn_borrow");
    expect_at(r + 9,  3, 1,        "dn_wrap_pulse");
    expect_at(r + 10, 3, 0,        "dn_wrap_clear");
    expect_at(r + 17, 0, 16'h9998, "dn_tick2");
    expect_at(r + 17, 3, 0,        "dn_nowrap");
    @(posedge clk); #1; load = 1'b0;
    drain();

    // Load colliding with a count tick, invalid nibbles
    do_reset(r);
    count_en = 1'b1; up_dn = 1'b1;
    expect_at(r + 7,  0, 16'h0000, "col_pre");
    expect_at(r + 8,  0, 16'h1030, "col_load_wins");
    expect_at(r + 8,  3, 0,        "col_wrap");
    expect_at(r + 15, 0, 16'h1030, "col_no_early_tick");
    expect_at(r + 16, 0, 16'h1031, "col_next_tick");
    expect_at(r + 21, 1, 4'b0010,  "col_sel1");
    expect_at(r + 21, 2, S3,       "col_seg1");
    repeat (7) @(posedge clk);
    #1;
    load = 1'b1; load_val = 16'h1A3F;
    @(posedge clk); #1; load = 1'b0;
    drain();

    // Asynchronous reset between edges
    #3;
    rst = 1'b0;
    #1;
    expect_at(cyc, 0, 0,       "arst_bcd");
    expect_at(cyc, 1, 4'b0001, "arst_sel");
    expect_at(cyc, 2, S0,      "arst_seg");
    expect_at(cyc, 3, 0,       "arst_wrap");
    ->chk_ev;

    // Leading-zero display
    do_reset(r);
    load = 1'b1; load_val = 16'h0070;
    expect_at(r + 4,  2, S7,      "lz_digit1");
    expect_at(r + 8,  2, BL,      "lz_digit2");
    expect_at(r + 12, 2, BL,      "lz_digit3");
    expect_at(r + 16, 1, 4'b0001, "lz_sel0");
    expect_at(r + 16, 2, S0,      "lz_digit0");
    @(posedge clk); #1; load = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
